// File: rtl/counter_checker.sv
// Reference-model monitor for an up/down counter: mirrors the control stream and flags output mismatches.
// Optional first-mismatch capture outputs are built when COUNTER_CHECKER_CAPTURE_EN is defined.
module counter_checker #(
  parameter int BIT_WIDTH = 4,
  parameter int LATENCY   = 1,
  parameter int ERR_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] mon_in,
  input  logic [1:0]           mon_ctrl,
  input  logic [BIT_WIDTH-1:0] mon_out,
  input  logic                 clr,
  output logic                 active,
  output logic                 err,
  output logic                 err_pulse,
  output logic [ERR_W-1:0]     err_count,
  output logic [BIT_WIDTH-1:0] exp_value
`ifdef COUNTER_CHECKER_CAPTURE_EN
  ,
  output logic [BIT_WIDTH-1:0] first_exp,
  output logic [BIT_WIDTH-1:0] first_obs
`endif
);

  typedef enum logic {SYNC, CHECK} state_t;

  state_t               state, state_next;
  logic [2:0]           sync_cnt, sync_cnt_next;
  logic [BIT_WIDTH-1:0] model, model_next;
  logic                 mismatch;

  // Load has priority; up/down wrap naturally through modulo arithmetic
  always_comb begin
    if (mon_ctrl[1])      model_next = mon_in;
    else if (mon_ctrl[0]) model_next = model + 1'b1;
    else                  model_next = model - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) model <= '0;
    else      model <= model_next;
  end

  generate
    if (LATENCY == 0) begin : g_lat0
      assign exp_value = model_next;
    end else if (LATENCY == 1) begin : g_lat1
      assign exp_value = model;
    end else begin : g_pipe
      logic [BIT_WIDTH-1:0] stage [LATENCY-1];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < LATENCY-1; i++) stage[i] <= '0;
        end else begin
          stage[0] <= model;
          for (int i = 1; i < LATENCY-1; i++) stage[i] <= stage[i-1];
        end
      end
      assign exp_value = stage[LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= SYNC;
      sync_cnt <= '0;
    end else begin
      state    <= state_next;
      sync_cnt <= sync_cnt_next;
    end
  end

  // SYNC waits LATENCY+1 edges so the delay line holds valid model values
  always_comb begin
    state_next    = state;
    sync_cnt_next = sync_cnt;
    if (state == SYNC) begin
      if (sync_cnt == 3'(LATENCY)) state_next = CHECK;
      else                         sync_cnt_next = sync_cnt + 3'd1;
    end
  end

  always_comb begin
    active = (state == CHECK);
  end

  assign mismatch = active && (mon_out != exp_value);

  // clr takes precedence over a mismatch on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err       <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else if (clr) begin
      err       <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else if (mismatch) begin
      err       <= 1'b1;
      err_pulse <= 1'b1;
      if (err_count != '1) err_count <= err_count + 1'b1;
    end else begin
      err_pulse <= 1'b0;
    end
  end

`ifdef COUNTER_CHECKER_CAPTURE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_exp <= '0;
      first_obs <= '0;
    end else if (clr) begin
      first_exp <= '0;
      first_obs <= '0;
    end else if (mismatch && !err) begin
      first_exp <= exp_value;
      first_obs <= mon_out;
    end
  end
`endif

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench for counter_checker (LATENCY=1) with a second ERR_W=2 instance for saturation.
module tb_counter_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mon_in;
  logic [1:0] mon_ctrl;
  logic [3:0] mon_out;
  logic       clr;

  logic       active, err, err_pulse;
  logic [7:0] err_count;
  logic [3:0] exp_value;
  logic       active2, err2, err_pulse2;
  logic [1:0] err_count2;
  logic [3:0] exp_value2;
`ifdef COUNTER_CHECKER_CAPTURE_EN
  logic [3:0] first_exp, first_obs, first_exp2, first_obs2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] m_model;
  logic       m_err, m_pulse, m_active;
  int         m_cnt8, m_cnt2, m_sync;
  logic [3:0] m_fe, m_fo;
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  counter_checker #(.BIT_WIDTH(4), .LATENCY(1), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .mon_in(mon_in), .mon_ctrl(mon_ctrl), .mon_out(mon_out), .clr(clr),
    .active(active), .err(err), .err_pulse(err_pulse), .err_count(err_count), .exp_value(exp_value)
`ifdef COUNTER_CHECKER_CAPTURE_EN
    , .first_exp(first_exp), .first_obs(first_obs)
`endif
  );

  counter_checker #(.BIT_WIDTH(4), .LATENCY(1), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .mon_in(mon_in), .mon_ctrl(mon_ctrl), .mon_out(mon_out), .clr(clr),
    .active(active2), .err(err2), .err_pulse(err_pulse2), .err_count(err_count2), .exp_value(exp_value2)
`ifdef COUNTER_CHECKER_CAPTURE_EN
    , .first_exp(first_exp2), .first_obs(first_obs2)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic resetModel();
    m_model = '0; m_err = 1'b0; m_pulse = 1'b0; m_active = 1'b0;
    m_cnt8 = 0; m_cnt2 = 0; m_sync = 0; m_fe = '0; m_fo = '0;
  endtask

  // Drives one cycle of stimulus, predicts the post-edge state, then checks it
  task automatic applyStimulus(input logic [1:0] ctrl, input logic [3:0] din,
                               input logic fault, input logic [3:0] fval, input logic clr_v);
    logic [3:0] obs_v;
    logic       mism;
    logic [3:0] expv;
    obs_v    = fault ? fval : m_model;
    mon_in   = din;
    mon_ctrl = ctrl;
    mon_out  = obs_v;
    clr      = clr_v;
    mism     = m_active && (obs_v != m_model);
    if (clr_v) begin
      m_err = 1'b0; m_pulse = 1'b0; m_cnt8 = 0; m_cnt2 = 0; m_fe = '0; m_fo = '0;
    end else if (mism) begin
      if (!m_err) begin m_fe = m_model; m_fo = obs_v; end
      m_err = 1'b1; m_pulse = 1'b1;
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end else begin
      m_pulse = 1'b0;
    end
    if (!m_active) begin
      m_sync++;
      if (m_sync == 2) m_active = 1'b1;
    end
    if (ctrl[1])      m_model = din;
    else if (ctrl[0]) m_model = m_model + 4'd1;
    else              m_model = m_model - 4'd1;
    exp_q.push_back(m_model);
    @(posedge clk);
    #1;
    expv = exp_q.pop_front();
    checkOutput("exp_value", 32'(exp_value), 32'(expv));
    checkOutput("active", 32'(active), 32'(m_active));
    checkOutput("err", 32'(err), 32'(m_err));
    checkOutput("err_pulse", 32'(err_pulse), 32'(m_pulse));
    checkOutput("err_count", 32'(err_count), 32'(m_cnt8));
    checkOutput("err_count_sat", 32'(err_count2), 32'(m_cnt2));
    checkOutput("err_sat", 32'(err2), 32'(m_err));
`ifdef COUNTER_CHECKER_CAPTURE_EN
    checkOutput("first_exp", 32'(first_exp), 32'(m_fe));
    checkOutput("first_obs", 32'(first_obs), 32'(m_fo));
`endif
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_active"}, 32'(active), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
    checkOutput({tag, "_err_count"}, 32'(err_count), 32'd0);
    checkOutput({tag, "_exp_value"}, 32'(exp_value), 32'd0);
    checkOutput({tag, "_err_count_sat"}, 32'(err_count2), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; mon_in = '0; mon_ctrl = '0; mon_out = '0; clr = 1'b0;
    resetModel();
    #12;
    checkAllZero("reset");
    rst = 1'b1;

    // Free-running up count with wrap 15 -> 0
    for (int i = 0; i < 20; i++) applyStimulus(2'b01, 4'd0, 1'b0, 4'd0, 1'b0);

    // Loads then down count through 0 -> 15
    applyStimulus(2'b11, 4'd3, 1'b0, 4'd0, 1'b0);
    applyStimulus(2'b10, 4'd2, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(2'b00, 4'd0, 1'b0, 4'd0, 1'b0);

    // Hold 7 and observe 5 for three cycles
    applyStimulus(2'b10, 4'd7, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b10, 4'd7, 1'b1, 4'd5, 1'b0);
    checkOutput("fault_count3", 32'(err_count), 32'd3);
    applyStimulus(2'b10, 4'd7, 1'b0, 4'd0, 1'b0);

    // Drive the 2-bit counter past saturation
    for (int i = 0; i < 6; i++) applyStimulus(2'b10, 4'd7, 1'b1, 4'd5, 1'b0);
    checkOutput("sat_count", 32'(err_count2), 32'd3);

    // clr coincident with a mismatch
    applyStimulus(2'b01, 4'd0, 1'b1, 4'd5, 1'b1);
    applyStimulus(2'b01, 4'd0, 1'b0, 4'd0, 1'b0);
    applyStimulus(2'b01, 4'd0, 1'b0, 4'd0, 1'b0);

    // Asynchronous reset with model=9 and err set
    applyStimulus(2'b10, 4'd9, 1'b0, 4'd0, 1'b0);
    applyStimulus(2'b10, 4'd9, 1'b1, 4'd5, 1'b0);
    #2 rst = 1'b0;
    #1 checkAllZero("midreset");
    resetModel();
    mon_out = '0;
    #2 rst = 1'b1;

    // Faults during SYNC must be ignored
    applyStimulus(2'b01, 4'd0, 1'b1, 4'd5, 1'b0);
    applyStimulus(2'b01, 4'd0, 1'b1, 4'd5, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(2'b01, 4'd0, 1'b0, 4'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
